// File: rtl/fifo_rr_drain_arbiter_if.sv
// Bundle between the source FWFT FIFOs, the round-robin drain arbiter and the shared consumer.
// The master modport is the arbiter's view; the slave modport is the FIFO/consumer side.
interface fifo_rr_drain_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  localparam int SRC_W = (N > 1) ? $clog2(N) : 1
);
  logic [N*WIDTH-1:0] fifo_dout;
  logic [N-1:0]       fifo_empty;
  logic [N-1:0]       fifo_rd_en;
  logic [WIDTH-1:0]   out_data;
  logic [SRC_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    input  fifo_dout, fifo_empty, out_ready,
    output fifo_rd_en, out_data, out_src, out_valid, busy
  );

  modport slave (
    output fifo_dout, fifo_empty, out_ready,
    input  fifo_rd_en, out_data, out_src, out_valid, busy
  );
endinterface

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of N FWFT FIFOs into one registered valid/ready stream.
// A grant lasts for a burst of up to MAX_BURST words, or for one whole packet in PKT_MODE.
module fifo_rr_drain_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int PKT_MODE  = 0,
  parameter int MAX_BURST = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  fifo_rr_drain_arbiter_if.master bus
);
  localparam int SRC_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] gnt;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] data_p1;
  logic [SRC_W-1:0] src_p1;
  logic             vld_p1;

  logic             adv;
  logic             pop;
  logic             gnt_empty;
  logic             any_req;
  logic             burst_last;
  logic             grant_end;
  logic [WIDTH-1:0] head;
  logic [SRC_W-1:0] sel;
  logic [SRC_W-1:0] ptr_next;
  logic [N-1:0]     rd_en;

  // The beat counter parks at MAX_BURST instead of wrapping on long packets.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(MAX_BURST)) ? v : v + 1'b1;
  endfunction

  assign adv        = !vld_p1 || bus.out_ready;
  assign gnt_empty  = bus.fifo_empty[gnt];
  assign head       = bus.fifo_dout[int'(gnt)*WIDTH +: WIDTH];
  assign pop        = (state == GRANT) && adv && !gnt_empty;
  assign any_req    = |(~bus.fifo_empty);
  assign burst_last = (cnt == CNT_W'(MAX_BURST - 1));
  assign ptr_next   = (gnt == SRC_W'(N - 1)) ? '0 : gnt + 1'b1;

  // Packet grants only end on the flagged last word; a dry source keeps the grant.
  always_comb begin
    grant_end = 1'b0;
    if (state == GRANT) begin
      if (PKT_MODE != 0) grant_end = pop && head[WIDTH-1];
      else               grant_end = (pop && burst_last) || (adv && gnt_empty);
    end
  end

  // Scan from the highest offset down so the first non-empty source after ptr wins.
  always_comb begin
    sel = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (!bus.fifo_empty[(int'(ptr) + k) % N]) sel = SRC_W'((int'(ptr) + k) % N);
    end
  end

  always_comb begin
    rd_en = '0;
    for (int i = 0; i < N; i++) rd_en[i] = pop && (gnt == SRC_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= sel;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (pop) cnt <= sat_inc(cnt);
          if (grant_end) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0 -> p1: popped head word lands in the output register one cycle after the pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
    end else if (pop) begin
      vld_p1  <= 1'b1;
      data_p1 <= head;
      src_p1  <= gnt;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_data   = data_p1;
  assign bus.out_src    = src_p1;
  assign bus.out_valid  = vld_p1;
  assign bus.busy       = (state == GRANT);

  a_rd_en_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.fifo_rd_en));
  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.fifo_rd_en & bus.fifo_empty) == '0);
  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p1 && !bus.out_ready) |=> ($stable(data_p1) && $stable(src_p1)));
endmodule
